// File: rtl/periph_bridge_pkg.sv
// Shared types and constants for the peripheral bridge and its interrupt controller.
package periph_bridge_pkg;

  localparam int unsigned HWINT_W     = 6;
  localparam int unsigned SLOT_STRIDE = 16;

  localparam logic [1:0] IC_PEND = 2'd0;
  localparam logic [1:0] IC_MASK = 2'd1;
  localparam logic [1:0] IC_MODE = 2'd2;
  localparam logic [1:0] IC_RAW  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_WAIT,
    ST_DONE
  } state_t;

  // Decoded destination of a CPU access
  typedef enum logic [1:0] {
    TGT_EXT,
    TGT_IC,
    TGT_NONE
  } target_t;

endpackage

// File: rtl/periph_bridge_if.sv
// CPU-side request bus, peripheral slot bus and interrupt lines of the bridge.
interface periph_bridge_if #(
  parameter int unsigned NSLOT = 6
);
  import periph_bridge_pkg::*;

  logic                  req;
  logic [31:0]           addr;
  logic                  we;
  logic [31:0]           wdata;
  logic [31:0]           rdata;
  logic                  ready;
  logic                  err;
  logic [NSLOT-1:0]      p_sel;
  logic [1:0]            p_addr;
  logic                  p_we;
  logic [31:0]           p_wdata;
  logic [32*NSLOT-1:0]   p_rdata;
  logic [NSLOT-1:0]      irq_in;
  logic [HWINT_W-1:0]    hwint;

  modport master (
    output req, addr, we, wdata, p_rdata, irq_in,
    input  rdata, ready, err, p_sel, p_addr, p_we, p_wdata, hwint
  );

  modport slave (
    input  req, addr, we, wdata, p_rdata, irq_in,
    output rdata, ready, err, p_sel, p_addr, p_we, p_wdata, hwint
  );

endinterface

// File: rtl/periph_irq_ctrl.sv
// Interrupt controller: input sync, level/edge pending, mask, W1C and registered hwint.
module periph_irq_ctrl
  import periph_bridge_pkg::*;
#(
  parameter int unsigned NSLOT = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NSLOT-1:0]   irq_in,
  input  logic               sel,
  input  logic [1:0]         offset,
  input  logic               we,
  input  logic [NSLOT-1:0]   wdata,
  output logic [NSLOT-1:0]   rdata_c,
  output logic [HWINT_W-1:0] hwint
);

  logic [NSLOT-1:0]   irq_q, mask_q, mode_q, edge_q;
  logic [NSLOT-1:0]   mask_d, mode_d, edge_d, w1c_c, pend_c;
  logic [HWINT_W-1:0] hwint_d;

  // Edge latches: a new rising edge beats a same-cycle W1C; leaving edge mode discards them
  always_comb begin
    mask_d  = (sel && we && offset == IC_MASK) ? wdata : mask_q;
    mode_d  = (sel && we && offset == IC_MODE) ? wdata : mode_q;
    w1c_c   = (sel && we && offset == IC_PEND) ? wdata : '0;
    edge_d  = ((edge_q & ~w1c_c) | (irq_in & ~irq_q & mode_q)) & mode_d;
    pend_c  = (mode_q & edge_q) | (~mode_q & irq_q);
    hwint_d = HWINT_W'(pend_c & mask_q);
  end

  always_comb begin
    rdata_c = '0;
    case (offset)
      IC_PEND: rdata_c = pend_c;
      IC_MASK: rdata_c = mask_q;
      IC_MODE: rdata_c = mode_q;
      IC_RAW:  rdata_c = irq_q;
      default: rdata_c = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_q  <= '0;
      mask_q <= '0;
      mode_q <= '0;
      edge_q <= '0;
      hwint  <= '0;
    end else begin
      irq_q  <= irq_in;
      mask_q <= mask_d;
      mode_q <= mode_d;
      edge_q <= edge_d;
      hwint  <= hwint_d;
    end
  end

endmodule

// File: rtl/periph_bridge.sv
// CPU-to-peripheral bridge: address decode, request/ready handshake with wait states,
// unmapped-address error and an embedded interrupt controller slot.
module periph_bridge
  import periph_bridge_pkg::*;
#(
  parameter int unsigned NSLOT     = 6,
  parameter logic [31:0] ADDR_BASE = 32'h0000_7F00,
  parameter int unsigned RD_WAIT   = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  periph_bridge_if.slave bus
);

  localparam int unsigned SLOT_W    = (NSLOT > 1) ? $clog2(NSLOT) : 1;
  localparam int unsigned CNT_W     = 3;
  localparam int unsigned STRIDE_SH = $clog2(SLOT_STRIDE);

  state_t            state_q, state_d;
  target_t           tgt_q, tgt_d, tgt_c;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic              we_q, we_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              ready_q, ready_d, err_q, err_d;
  logic [NSLOT-1:0]  p_sel_q, p_sel_d;
  logic              p_we_q, p_we_d;
  logic [1:0]        p_addr_q, p_addr_d;
  logic [31:0]       p_wdata_q, p_wdata_d;
  logic [31:0]       idx_c, slot_rdata_c;
  logic              finish_c, ic_sel_c;
  logic [NSLOT-1:0]  ic_rdata_c;

  // Slot decode; addresses below the base wrap and are caught explicitly
  always_comb begin
    idx_c = (bus.addr - ADDR_BASE) >> STRIDE_SH;
    if (bus.addr < ADDR_BASE)         tgt_c = TGT_NONE;
    else if (idx_c < 32'(NSLOT))      tgt_c = TGT_EXT;
    else if (idx_c == 32'(NSLOT))     tgt_c = TGT_IC;
    else                              tgt_c = TGT_NONE;
  end

  always_comb begin
    slot_rdata_c = '0;
    for (int unsigned i = 0; i < NSLOT; i++) begin
      if (slot_q == SLOT_W'(i)) slot_rdata_c = bus.p_rdata[32*i +: 32];
    end
  end

  assign ic_sel_c = (state_q == ST_ACCESS) && (tgt_q == TGT_IC);

  periph_irq_ctrl #(.NSLOT(NSLOT)) u_irq (
    .clk     (clk),
    .rst_n   (rst_n),
    .irq_in  (bus.irq_in),
    .sel     (ic_sel_c),
    .offset  (p_addr_q),
    .we      (ic_sel_c & we_q),
    .wdata   (p_wdata_q[NSLOT-1:0]),
    .rdata_c (ic_rdata_c),
    .hwint   (bus.hwint)
  );

  always_comb begin
    state_d   = state_q;
    tgt_d     = tgt_q;
    slot_d    = slot_q;
    we_d      = we_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    ready_d   = 1'b0;
    err_d     = 1'b0;
    p_sel_d   = p_sel_q;
    p_we_d    = 1'b0;
    p_addr_d  = p_addr_q;
    p_wdata_d = p_wdata_q;
    finish_c  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.req) begin
          state_d   = ST_ACCESS;
          tgt_d     = tgt_c;
          slot_d    = SLOT_W'(idx_c);
          we_d      = bus.we;
          p_addr_d  = bus.addr[3:2];
          p_wdata_d = bus.wdata;
          p_sel_d   = (tgt_c == TGT_EXT) ? (NSLOT'(1) << SLOT_W'(idx_c)) : '0;
          p_we_d    = bus.we && (tgt_c == TGT_EXT);
        end
      end
      ST_ACCESS: begin
        if (tgt_q == TGT_IC) rdata_d = 32'(ic_rdata_c);
        if (RD_WAIT == 0) begin
          finish_c = 1'b1;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = CNT_W'(RD_WAIT - 1);
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) finish_c = 1'b1;
        else             cnt_d = cnt_q - CNT_W'(1);
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Common exit of the last select cycle; IC data was already captured in ACCESS
    if (finish_c) begin
      state_d = ST_DONE;
      p_sel_d = '0;
      ready_d = 1'b1;
      err_d   = (tgt_q == TGT_NONE);
      if (tgt_q == TGT_EXT)       rdata_d = slot_rdata_c;
      else if (tgt_q == TGT_NONE) rdata_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      tgt_q     <= TGT_NONE;
      slot_q    <= '0;
      we_q      <= 1'b0;
      cnt_q     <= '0;
      rdata_q   <= '0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      p_sel_q   <= '0;
      p_we_q    <= 1'b0;
      p_addr_q  <= '0;
      p_wdata_q <= '0;
    end else begin
      state_q   <= state_d;
      tgt_q     <= tgt_d;
      slot_q    <= slot_d;
      we_q      <= we_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
      p_sel_q   <= p_sel_d;
      p_we_q    <= p_we_d;
      p_addr_q  <= p_addr_d;
      p_wdata_q <= p_wdata_d;
    end
  end

  assign bus.rdata   = rdata_q;
  assign bus.ready   = ready_q;
  assign bus.err     = err_q;
  assign bus.p_sel   = p_sel_q;
  assign bus.p_we    = p_we_q;
  assign bus.p_addr  = p_addr_q;
  assign bus.p_wdata = p_wdata_q;

endmodule

// File: tb/tb_periph_bridge.sv
// Self-checking bench for periph_bridge: one instance with three wait states and one with none.
module tb_periph_bridge;

  localparam logic [31:0] BASE = 32'h0000_7F00;
  localparam logic [31:0] IC   = BASE + 32'h60;
  localparam int          RW   = 3;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic [31:0] slot_data [6];
  logic [5:0]  hw_trace [0:RW+1];

  periph_bridge_if #(.NSLOT(6)) b ();
  periph_bridge_if #(.NSLOT(6)) b0 ();

  periph_bridge #(.NSLOT(6), .ADDR_BASE(BASE), .RD_WAIT(RW)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b)
  );

  periph_bridge #(.NSLOT(6), .ADDR_BASE(BASE), .RD_WAIT(0)) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference decode: 0..5 external slot, 6 interrupt controller, -1 unmapped
  function automatic int target_of(input logic [31:0] a);
    logic [31:0] idx;
    if (a < BASE) return -1;
    idx = (a - BASE) / 16;
    if (idx < 6) return int'(idx);
    if (idx == 6) return 6;
    return -1;
  endfunction

  task automatic load_slots();
    for (int i = 0; i < 6; i++) b.p_rdata[32*i +: 32] = slot_data[i];
  endtask

  // One CPU access on the main instance with cycle-exact handshake checks
  task automatic do_access(input logic [31:0] a, input logic w, input logic [31:0] d,
                           input int req_k, input int irq_k, input logic [5:0] irq_v,
                           output logic [31:0] rd);
    int         tgt;
    logic       ext;
    logic [5:0] exp_sel;
    logic       exp_we;
    tgt     = target_of(a);
    ext     = (tgt >= 0 && tgt < 6);
    exp_sel = ext ? (6'b1 << tgt) : 6'b0;
    load_slots();
    b.req = 1'b1; b.addr = a; b.we = w; b.wdata = d;
    tick();
    b.req = 1'b0;
    for (int k = 0; k <= RW; k++) begin
      hw_trace[k] = b.hwint;
      exp_we = (k == 0) && w && ext;
      checks++;
      if (b.p_sel !== exp_sel || b.ready !== 1'b0 || b.p_we !== exp_we) begin
        errors++;
        $display("FAIL access a=%h k=%0d: p_sel=%b ready=%b p_we=%b, expected p_sel=%b ready=0 p_we=%b",
                 a, k, b.p_sel, b.ready, b.p_we, exp_sel, exp_we);
      end
      if (k == 0) begin
        checks++;
        if (b.p_addr !== a[3:2] || (ext && b.p_wdata !== d)) begin
          errors++;
          $display("FAIL access a=%h p_addr/p_wdata: got %0d/%h expected %0d/%h", a, b.p_addr, b.p_wdata, a[3:2], d);
        end
      end
      if (k == req_k) begin b.req = 1'b1; b.addr = BASE; b.we = 1'b0; end
      if (k == irq_k) b.irq_in = irq_v;
      tick();
      b.req = 1'b0;
    end
    hw_trace[RW+1] = b.hwint;
    checks++;
    if (b.ready !== 1'b1 || b.err !== (tgt < 0) || b.p_sel !== 6'b0) begin
      errors++;
      $display("FAIL access a=%h done: ready=%b err=%b p_sel=%b, expected ready=1 err=%b p_sel=0",
               a, b.ready, b.err, b.p_sel, (tgt < 0));
    end
    if (tgt < 0 || (ext && !w)) begin
      checks++;
      if (b.rdata !== (ext ? slot_data[tgt] : 32'h0)) begin
        errors++;
        $display("FAIL access a=%h rdata: got %h expected %h", a, b.rdata, ext ? slot_data[tgt] : 32'h0);
      end
    end
    rd = b.rdata;
    tick();
    tick();
    checks++;
    if (b.ready !== 1'b0 || b.p_sel !== 6'b0) begin
      errors++;
      $display("FAIL access a=%h after: ready=%b p_sel=%b, expected both 0", a, b.ready, b.p_sel);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if ({b.rdata, b.ready, b.err, b.p_sel, b.p_we, b.p_addr, b.p_wdata, b.hwint} !== '0) begin
      errors++;
      $display("FAIL reset main: rdata=%h ready=%b err=%b p_sel=%b p_we=%b p_addr=%0d p_wdata=%h hwint=%b, expected all 0",
               b.rdata, b.ready, b.err, b.p_sel, b.p_we, b.p_addr, b.p_wdata, b.hwint);
    end
    checks++;
    if ({b0.rdata, b0.ready, b0.err, b0.p_sel, b0.p_we, b0.hwint} !== '0) begin
      errors++;
      $display("FAIL reset nowait: rdata=%h ready=%b p_sel=%b hwint=%b, expected all 0", b0.rdata, b0.ready, b0.p_sel, b0.hwint);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_read_nowait();
    logic [31:0] v;
    for (int n = 0; n < 3; n++) begin
      int s;
      s = (n == 0) ? 0 : int'($urandom_range(0, 5));
      v = (n == 0) ? 32'hDEAD_BEEF : $urandom;
      b0.p_rdata = '0;
      b0.p_rdata[32*s +: 32] = v;
      b0.req = 1'b1; b0.addr = BASE + 32'(16*s) + 32'h4; b0.we = 1'b0;
      tick();
      b0.req = 1'b0;
      checks++;
      if (b0.p_sel !== (6'b1 << s) || b0.p_addr !== 2'd1 || b0.ready !== 1'b0) begin
        errors++;
        $display("FAIL nowait sel: p_sel=%b p_addr=%0d ready=%b, expected %b 1 0", b0.p_sel, b0.p_addr, b0.ready, 6'b1 << s);
      end
      tick();
      checks++;
      if (b0.ready !== 1'b1 || b0.err !== 1'b0 || b0.rdata !== v || b0.p_sel !== 6'b0) begin
        errors++;
        $display("FAIL nowait done: ready=%b err=%b rdata=%h p_sel=%b, expected 1 0 %h 0", b0.ready, b0.err, b0.rdata, b0.p_sel, v);
      end
      tick();
      checks++;
      if (b0.ready !== 1'b0 || b0.rdata !== v) begin
        errors++;
        $display("FAIL nowait hold: ready=%b rdata=%h, expected 0 %h", b0.ready, b0.rdata, v);
      end
    end
  endtask

  task automatic test_write_wait();
    logic [31:0] rd;
    do_access(BASE + 32'h20, 1'b1, 32'h1234_5678, -1, -1, 6'h0, rd);
  endtask

  task automatic test_unmapped();
    logic [31:0] rd;
    for (int i = 0; i < 6; i++) slot_data[i] = $urandom | 32'h1;
    do_access(BASE + 32'h14, 1'b0, 32'h0, -1, -1, 6'h0, rd);
    do_access(BASE + 32'h80, 1'b0, 32'h0, 1, -1, 6'h0, rd);
    do_access(BASE - 32'h4, 1'b1, 32'hA5A5_A5A5, RW, -1, 6'h0, rd);
  endtask

  task automatic test_random();
    logic [31:0] a, rd;
    for (int n = 0; n < 16; n++) begin
      for (int i = 0; i < 6; i++) slot_data[i] = $urandom;
      case ($urandom_range(0, 4))
        0:       a = BASE + 32'h70 + 32'(4 * $urandom_range(0, 35));
        1:       a = BASE - 32'(4 * $urandom_range(1, 64));
        default: a = BASE + 32'(16 * $urandom_range(0, 5)) + 32'(4 * $urandom_range(0, 3));
      endcase
      do_access(a, 1'($urandom_range(0, 1)), $urandom, -1, -1, 6'h0, rd);
    end
  endtask

  task automatic test_irq_edge();
    logic [31:0] rd;
    do_access(IC + 32'h4, 1'b1, 32'h3F, -1, -1, 6'h0, rd);
    do_access(IC + 32'h8, 1'b1, 32'h01, -1, -1, 6'h0, rd);
    b.irq_in = 6'h01;
    tick();
    b.irq_in = 6'h00;
    checks++;
    if (b.hwint !== 6'h00) begin errors++; $display("FAIL edge early: hwint=%b expected 000000", b.hwint); end
    tick();
    checks++;
    if (b.hwint !== 6'h01) begin errors++; $display("FAIL edge rise: hwint=%b expected 000001", b.hwint); end
    repeat (4) tick();
    checks++;
    if (b.hwint !== 6'h01) begin errors++; $display("FAIL edge held: hwint=%b expected 000001", b.hwint); end
    do_access(IC + 32'h0, 1'b0, 32'h0, -1, -1, 6'h0, rd);
    checks++;
    if (rd !== 32'h1) begin errors++; $display("FAIL pend read: got %h expected 00000001", rd); end
    do_access(IC + 32'hC, 1'b0, 32'h0, -1, -1, 6'h0, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL raw read: got %h expected 00000000", rd); end
    do_access(IC + 32'h0, 1'b1, 32'h01, -1, -1, 6'h0, rd);
    checks++;
    if (hw_trace[1] !== 6'h01 || hw_trace[2] !== 6'h00 || b.hwint !== 6'h00) begin
      errors++;
      $display("FAIL w1c: hwint trace %b,%b now %b, expected 000001,000000 now 000000", hw_trace[1], hw_trace[2], b.hwint);
    end
    b.irq_in = 6'h01;
    tick();
    b.irq_in = 6'h00;
    tick();
    tick();
    do_access(IC + 32'h0, 1'b1, 32'h01, -1, 0, 6'h01, rd);
    b.irq_in = 6'h00;
    checks++;
    if (hw_trace[2] !== 6'h01 || hw_trace[RW+1] !== 6'h01 || b.hwint !== 6'h01) begin
      errors++;
      $display("FAIL w1c vs edge: hwint trace %b,%b now %b, expected all 000001", hw_trace[2], hw_trace[RW+1], b.hwint);
    end
    do_access(IC + 32'h0, 1'b0, 32'h0, -1, -1, 6'h0, rd);
    checks++;
    if (rd !== 32'h1) begin errors++; $display("FAIL pend after w1c vs edge: got %h expected 00000001", rd); end
  endtask

  task automatic test_irq_level();
    logic [31:0] rd;
    logic [5:0]  m, r;
    do_access(IC + 32'h8, 1'b1, 32'h00, -1, -1, 6'h0, rd);
    do_access(IC + 32'h4, 1'b1, 32'h3F, -1, -1, 6'h0, rd);
    b.irq_in = 6'h02;
    tick();
    checks++;
    if (b.hwint !== 6'h00) begin errors++; $display("FAIL level early: hwint=%b expected 000000", b.hwint); end
    tick();
    checks++;
    if (b.hwint !== 6'h02) begin errors++; $display("FAIL level rise: hwint=%b expected 000010", b.hwint); end
    b.irq_in = 6'h00;
    tick();
    checks++;
    if (b.hwint !== 6'h02) begin errors++; $display("FAIL level lag: hwint=%b expected 000010", b.hwint); end
    tick();
    checks++;
    if (b.hwint !== 6'h00) begin errors++; $display("FAIL level fall: hwint=%b expected 000000", b.hwint); end
    b.irq_in = 6'h02;
    tick();
    tick();
    do_access(IC + 32'h4, 1'b1, 32'h00, -1, -1, 6'h0, rd);
    checks++;
    if (hw_trace[1] !== 6'h02 || hw_trace[2] !== 6'h00) begin
      errors++;
      $display("FAIL mask off: hwint trace %b,%b expected 000010,000000", hw_trace[1], hw_trace[2]);
    end
    for (int n = 0; n < 6; n++) begin
      m = 6'($urandom_range(0, 63));
      r = 6'($urandom_range(0, 63));
      do_access(IC + 32'h4, 1'b1, 32'(m), -1, -1, 6'h0, rd);
      b.irq_in = r;
      tick();
      tick();
      checks++;
      if (b.hwint !== (r & m)) begin errors++; $display("FAIL level rand: hwint=%b expected %b", b.hwint, r & m); end
      do_access(IC + 32'hC, 1'b0, 32'h0, -1, -1, 6'h0, rd);
      checks++;
      if (rd !== 32'(r)) begin errors++; $display("FAIL raw rand: got %h expected %h", rd, 32'(r)); end
    end
    b.irq_in = 6'h00;
    tick();
  endtask

  task automatic test_mode_discard();
    logic [31:0] rd;
    do_access(IC + 32'h4, 1'b1, 32'h3F, -1, -1, 6'h0, rd);
    do_access(IC + 32'h8, 1'b1, 32'h3F, -1, -1, 6'h0, rd);
    b.irq_in = 6'h24;
    tick();
    b.irq_in = 6'h00;
    tick();
    checks++;
    if (b.hwint !== 6'h24) begin errors++; $display("FAIL multi edge: hwint=%b expected 100100", b.hwint); end
    do_access(IC + 32'h8, 1'b1, 32'h00, -1, -1, 6'h0, rd);
    do_access(IC + 32'h8, 1'b1, 32'h3F, -1, -1, 6'h0, rd);
    do_access(IC + 32'h0, 1'b0, 32'h0, -1, -1, 6'h0, rd);
    checks++;
    if (rd !== 32'h0 || b.hwint !== 6'h00) begin
      errors++;
      $display("FAIL mode discard: pend=%h hwint=%b expected 00000000 000000", rd, b.hwint);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    slot_data[3] = 32'hCAFE_0001;
    do_access(BASE + 32'h30, 1'b0, 32'h0, -1, -1, 6'h0, rd);
    do_access(IC + 32'h8, 1'b1, 32'h00, -1, -1, 6'h0, rd);
    b.irq_in = 6'h08;
    tick();
    tick();
    b.req = 1'b1; b.addr = BASE + 32'h2C; b.we = 1'b1; b.wdata = 32'h5A5A_0F0F;
    tick();
    b.req = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    b.irq_in = 6'h00;
    #1;
    checks++;
    if ({b.rdata, b.ready, b.err, b.p_sel, b.p_we, b.p_addr, b.p_wdata, b.hwint} !== '0) begin
      errors++;
      $display("FAIL reset mid: rdata=%h ready=%b err=%b p_sel=%b p_we=%b p_addr=%0d p_wdata=%h hwint=%b, expected all 0",
               b.rdata, b.ready, b.err, b.p_sel, b.p_we, b.p_addr, b.p_wdata, b.hwint);
    end
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++;
      if (b.ready !== 1'b0 || b.p_sel !== 6'b0) begin
        errors++;
        $display("FAIL idle after reset k=%0d: ready=%b p_sel=%b expected 0 0", k, b.ready, b.p_sel);
      end
    end
    do_access(IC + 32'h4, 1'b0, 32'h0, -1, -1, 6'h0, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL mask after reset: got %h expected 00000000", rd); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    b.req = 1'b0; b.addr = '0; b.we = 1'b0; b.wdata = '0; b.p_rdata = '0; b.irq_in = '0;
    b0.req = 1'b0; b0.addr = '0; b0.we = 1'b0; b0.wdata = '0; b0.p_rdata = '0; b0.irq_in = '0;
    for (int i = 0; i < 6; i++) slot_data[i] = '0;
    test_reset();
    test_read_nowait();
    test_write_wait();
    test_unmapped();
    test_random();
    test_irq_edge();
    test_irq_level();
    test_mode_discard();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/periph_bridge.md
# periph_bridge

Parametrised successor to the fixed-decode south bridge: a multi-cycle bridge between the CPU data port and `NSLOT` memory-mapped peripherals. It runs a request/ready handshake with configurable wait states, reports an error for unmapped addresses, and contains a built-in interrupt controller. That controller adds per-source mask, level/edge mode and pending latches, and drives the CPU `HWInt[7:2]` lines.

## Interface
- `NSLOT`, 6: number of external peripheral slots (1..6).
- `ADDR_BASE`, 32'h0000_7F00: byte address of slot 0; must be 16-byte aligned.
- `RD_WAIT`, 0: extra cycles `sel` is held before read data is sampled (0..7).

Ports:
- `clk` input 1: the block's single clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `req` input 1: single-cycle request pulse from the CPU.
- `addr` input 32: byte address, word aligned.
- `we` input 1: 1 = write, 0 = read.
- `wdata` input 32: write data.
- `rdata` output 32: read data, held until the next accepted request.
- `ready` output 1: one-cycle completion pulse.
- `err` output 1: valid with `ready`; 1 = unmapped address.
- `p_sel` output NSLOT: one-hot slot select.
- `p_addr` output 2: word offset within the slot (`addr[3:2]`).
- `p_we` output 1: single-cycle write strobe.
- `p_wdata` output 32: write data to peripherals.
- `p_rdata` input 32*NSLOT: slot *i* drives bits [32i+31:32i], combinational.
- `irq_in` input NSLOT: raw peripheral interrupt lines.
- `hwint` output 6: interrupt lines to the CPU; bits ≥ NSLOT are tied to 0.

## Operation
- Slot index is `(addr - ADDR_BASE) >> 4`.
  - Indices 0..NSLOT-1 select external slots.
  - Index NSLOT selects the internal interrupt controller (IC).
  - Anything else, including `addr < ADDR_BASE`, is unmapped.
- FSM states: IDLE, ACCESS, WAIT, DONE.
  - IDLE, `req`=1: latch `addr`, `we`, `wdata` and the slot index, then go to ACCESS.
  - ACCESS: drive `p_sel`, `p_addr`, `p_wdata`; `p_we`=`we` for this cycle only. Go to WAIT if `RD_WAIT`>0, else DONE.
  - WAIT: `p_sel` held, `p_we`=0. Count down `RD_WAIT` cycles, then go to DONE.
  - DONE: `ready`=1 and `err` valid. On reads, `rdata` has been captured from the selected slot in the last `p_sel` cycle. Return to IDLE.
- Unmapped access: `p_sel` stays 0 and no write occurs. `rdata` is loaded with 0 and `err`=1 in DONE. Latency is the same as a mapped access.
- IC access: `p_sel` stays 0 and the internal register is read or written instead.
- `req` outside IDLE is ignored; no queueing.
- IC registers, with their word offsets:
  - 0 PEND: read-only view; a write of 1 clears the corresponding edge-mode bit.
  - 1 MASK: read/write.
  - 2 MODE: read/write; 1 = edge, 0 = level.
  - 3 RAW: read-only, shows `irq_q`.
  - All are NSLOT bits wide, zero-extended on read.
- `irq_q` is `irq_in` registered once.
  - Level source: PEND bit = `irq_q` bit.
  - Edge source: PEND bit is set on `irq_in & ~irq_q` and cleared by a W1C write.
  - A rising edge in the same cycle as its W1C leaves the bit set (set wins).
- Writing MODE from edge to level discards the latched edge pending state.
- `hwint` = registered (PEND & MASK).

## Timing
- Reset (asynchronous, any state, including mid-access): FSM returns to IDLE.
  - `rdata`, `ready`, `err`, `p_sel`, `p_we`, `p_addr`, `p_wdata`, `hwint` = 0.
  - MASK, MODE, PEND, `irq_q` = 0.
- Request accepted at cycle T:
  - `p_sel` asserted T+1 .. T+1+`RD_WAIT`.
  - `ready` at T+2+`RD_WAIT`.
  - The earliest next accept is T+3+`RD_WAIT`.
- IC writes take effect at the clock edge ending ACCESS; IC reads are captured at that same edge.
- Interrupt path:
  - `irq_in` rising at edge E sets `irq_q` and edge PEND at E.
  - `hwint` rises at E+1.
  - Worst case is 2 cycles from pin to `hwint`.

## Structure
- Package `periph_bridge_pkg`:
  - FSM state enum.
  - Slot stride constant (16).
  - IC register offsets (PEND=0, MASK=1, MODE=2, RAW=3).
  - `HWINT_W` = 6.
- Sub-module `periph_irq_ctrl`: holds `irq_q`, PEND, MASK and MODE, edge detect, W1C, and the `hwint` register. Its register port (sel, offset, we, wdata, rdata) is driven by the bridge FSM.

## Test plan
- Reset then read from `ADDR_BASE`+0x04 with slot 0 driving 0xDEADBEEF, `RD_WAIT`=0. Required: `p_sel`=000001 and `p_addr`=1 at T+1; `ready`=1, `err`=0, `rdata`=0xDEADBEEF at T+2.
- Write 0x12345678 to `ADDR_BASE`+0x20 (slot 2), `RD_WAIT`=3. Required: `p_we` high for exactly one cycle; `p_sel`=000100 for 4 cycles; `ready` at T+5.
- Access `ADDR_BASE`+0x80 and `ADDR_BASE`-4, both unmapped. Required: `p_sel` stays 0, `err`=1 and `rdata`=0 at `ready`; a second `req` pulsed during WAIT is ignored.
- Write MASK=0x3F and MODE=0x01, then pulse `irq_in[0]` for 1 cycle. Required: `hwint[0]`=1 two cycles later and held. W1C 0x01 to PEND clears it, unless a new edge lands in the same cycle, in which case it stays 1.
- Level source 1 with MASK bit 1 set: `hwint[1]` follows `irq_in[1]` with 2-cycle delay. Setting MASK=0 drops `hwint[1]` on the next cycle.
- Deassert `rst_n` in the middle of WAIT. Required: all outputs 0 immediately (asynchronous reset); FSM in IDLE; MASK reads 0 after release.
